// File: rtl/disp_s2p_rx.sv
// disp_s2p_rx: oversampling receiver for the 4-wire display shift protocol
// (sclk, clrn, sout, pen). Bits are shifted in MSB-first on each sclk rise
// and a complete frame is latched on the rising edge of pen. Short or
// overrun frames produce a one-cycle error pulse instead of a data update.
module disp_s2p_rx #(
    parameter int DATA_BITS       = 64,
    parameter int DATA_COUNT_BITS = 6,
    parameter int FCNT_W          = 16
) (
    input  logic                       clk_100mhz,
    input  logic                       rst,
    input  logic                       sclk_in,
    input  logic                       sclrn_in,
    input  logic                       sout_in,
    input  logic                       pen_in,
    output logic [DATA_BITS-1:0]       data_out,
    output logic                       frame_valid,
    output logic                       frame_err,
    output logic [DATA_COUNT_BITS:0]   bit_cnt,
    output logic [FCNT_W-1:0]          frame_cnt,
    output logic                       busy
);

    localparam int CW = DATA_COUNT_BITS + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DATA_BITS);
    localparam logic [CW-1:0] OVR_CNT  = CW'(DATA_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Bit counter increment that sticks at the overrun marker.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v >= OVR_CNT)
            return OVR_CNT;
        else
            return v + 1'b1;
    endfunction

    // Wire order in the sync vectors: [3]=pen, [2]=sout, [1]=sclrn, [0]=sclk.
    // _p0/_p1 form the 2-FF synchronizer, _p2 is the history stage.
    logic [3:0] in_p0, in_p1, in_p2;

    state_t                state, state_nxt;
    logic [DATA_BITS-1:0]  shreg;

    logic sclk_rise, pen_rise, clr_act, sout_s;
    logic pen_ev, frame_good;

    assign sclk_rise  = in_p1[0] & ~in_p2[0];
    assign clr_act    = ~in_p1[1];
    assign sout_s     = in_p1[2];
    assign pen_rise   = in_p1[3] & ~in_p2[3];
    // Clear overrides the frame end; no decision is taken while clearing.
    assign pen_ev     = pen_rise & ~clr_act;
    assign frame_good = (bit_cnt == FULL_CNT);

    // Synchronize the asynchronous serial wires and keep one cycle of history.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            in_p0 <= '0;
            in_p1 <= '0;
            in_p2 <= '0;
        end else begin
            in_p0 <= {pen_in, sout_in, sclrn_in, sclk_in};
            in_p1 <= in_p0;
            in_p2 <= in_p1;
        end
    end

    // State register.
    always_ff @(posedge clk_100mhz) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state: clear, then pen, then sclk; a pen rise discards a coincident sclk bit.
    always_comb begin
        state_nxt = state;
        if (clr_act || pen_rise)
            state_nxt = ST_IDLE;
        else if (sclk_rise)
            state_nxt = (sat_inc(bit_cnt) == FULL_CNT) ? ST_FULL : ST_SHIFT;
    end

    // FSM outputs.
    always_comb begin
        busy = (state != ST_IDLE);
    end

    // Shift register and bit counter; both restart after every frame end or clear.
    always_ff @(posedge clk_100mhz) begin
        if (rst || clr_act || pen_rise) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (sclk_rise) begin
            shreg   <= {shreg[DATA_BITS-2:0], sout_s};
            bit_cnt <= sat_inc(bit_cnt);
        end
    end

    // Frame latch decision on the pen rise, using the count before this edge.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            data_out    <= '0;
            frame_cnt   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= pen_ev & frame_good;
            frame_err   <= pen_ev & ~frame_good;
            if (pen_ev && frame_good) begin
                data_out  <= shreg;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/disp_s2p_rx.md
Name: disp_s2p_rx

Overview:
- Serial-to-parallel receiver for the 4-wire display/LED shift protocol (sclk, clrn, sout, pen) driven by the P2S and LED_P2S transmitters.
- Oversamples the four serial wires in the clk_100mhz domain, deserializes MSB-first, and latches a full frame on the rising edge of pen.
- Used as an on-chip loopback checker and as the bench-side model of the display board's shift-register chain.

Parameters:
- DATA_BITS, 64, frame width in bits.
- DATA_COUNT_BITS, 6, log2(DATA_BITS); the bit counter is DATA_COUNT_BITS+1 wide so it can hold DATA_BITS and overflow.
- FCNT_W, 16, width of the good-frame counter.

Ports:
- clk_100mhz  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sclk_in  input  1  serial shift clock from the transmitter; asynchronous to clk_100mhz.
- sclrn_in  input  1  serial clear, active-low; asynchronous.
- sout_in  input  1  serial data; asynchronous.
- pen_in  input  1  parallel-load enable; a rising edge ends the frame.
- data_out  output  DATA_BITS  last good frame.
- frame_valid  output  1  one-cycle pulse when data_out updates.
- frame_err  output  1  one-cycle pulse on a bad frame.
- bit_cnt  output  DATA_COUNT_BITS+1  bits shifted in the current frame.
- frame_cnt  output  FCNT_W  count of good frames; wraps.
- busy  output  1  high while in SHIFT or FULL.

Behaviour:
- Synchronizers:
  - Each serial input passes through a 2-FF synchronizer, then one history FF.
  - The edge of X is detected when sync2_X=1 and hist_X=0.
  - The sout value used is sync2_sout in the same cycle the sclk rising edge is detected.
  - Latency from sclk_in rising to the shift-register update is 3 clk_100mhz cycles.
- Minimum sclk_in high and low time is 3 clk_100mhz cycles; faster clocks are unsupported.
- Shift rule: on a detected sclk rise, shreg <= {shreg[DATA_BITS-2:0], sout}. The first received bit ends in data_out[DATA_BITS-1].
- Bit counter:
  - bit_cnt increments on each sclk rise, saturating at DATA_BITS+1.
  - A value of DATA_BITS+1 means overrun.
- States:
  - IDLE → SHIFT on the first sclk rise while sync2_sclrn=1.
  - SHIFT → FULL when bit_cnt reaches DATA_BITS.
  - FULL → SHIFT(overrun) on a further sclk rise; bit_cnt is set to DATA_BITS+1.
  - Any state → IDLE on a pen rise, after the latch decision.
- Latch decision (cycle of the pen rise):
  - bit_cnt==DATA_BITS: data_out <= shreg, frame_valid=1, frame_cnt+1.
  - bit_cnt≠DATA_BITS (short or overrun), including a pen rise in IDLE with bit_cnt=0: frame_err=1, data_out holds.
  - In all cases bit_cnt <= 0 and shreg <= 0 on the next edge.
- Clear: while sync2_sclrn=0, shreg=0, bit_cnt=0, state=IDLE, and sclk rises are ignored. There is no err pulse for the clear itself.
- Simultaneous events in one cycle:
  - sclrn low beats everything.
  - A pen rise together with an sclk rise: the sclk bit is discarded, and the decision uses bit_cnt before that edge.
- Reset: rst=1 clears synchronizers, history FFs, shreg, bit_cnt, state=IDLE, data_out=0, frame_cnt=0, frame_valid=0, frame_err=0, busy=0. Reset mid-frame discards the partial frame without an error pulse.
- frame_cnt wraps from 2^FCNT_W-1 to 0.
- frame_valid and frame_err are never high in the same cycle.

Test Plan:
- Reset, then shift 64 bits of 0x0123_4567_89AB_CDEF MSB-first at sclk period 8 cycles, then pen rise → frame_valid pulses once, data_out=0x0123456789ABCDEF, frame_cnt=1, busy=0.
- Shift 63 bits, then pen → frame_err pulses, data_out unchanged, frame_cnt unchanged; 65 bits then pen → frame_err pulses.
- Shift 40 bits, drop sclrn for 5 cycles, then send a full frame of 0xFFFF_0000_FFFF_0000 with pen → valid, data_out=0xFFFF0000FFFF0000, no error pulse.
- Assert rst after 30 bits, then send a full frame → no error pulse, frame_cnt=1, correct data; pen rise with sclk rise on the same cycle after exactly 64 bits → valid.
- DATA_BITS=16, DATA_COUNT_BITS=4, FCNT_W=2: send 5 frames of 0xA5C3 → data_out=0xA5C3, frame_cnt sequence 1,2,3,0,1.
